dac_apb_multichannel: RTL and testbench

Parametrised APB slave that drives NCH DAC channels of DW bits each, successor to the single-channel 12-bit DAC APB interface. Each channel has a shadow register written over APB and an output register driving the DAC pins. Outputs update either immediately on write or simultaneously across all channels on a software LOAD strobe or a programmable periodic timer. It sits on the APB peripheral bus of the mriscv SoC alongside the other APB slaves.

---
 rtl/dac_apb_multichannel.sv | 170 +++++++++++++++++
 tb/tb_dac_apb_multichannel.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_apb_multichannel.sv
// APB slave driving NCH DAC channels: per-channel shadow/output registers,
// immediate or synchronised update via software LOAD strobe or periodic timer.
module dac_apb_multichannel #(
  parameter int NCH = 4,
  parameter int DW  = 12,
  parameter int TW  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR,
  output logic [NCH*DW-1:0] DATA,
  output logic              UPDATE
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     prdata_q, prdata_d;
  logic            pslverr_q, pslverr_d;
  logic [DW-1:0]   shadow_q [NCH];
  logic [DW-1:0]   shadow_d [NCH];
  logic [DW-1:0]   dout_q [NCH];
  logic [DW-1:0]   dout_d [NCH];
  logic            mode_q, mode_d, ten_q, ten_d, pend_q, pend_d;
  logic [TW-1:0]   period_q, period_d, cnt_q, cnt_d;
  logic            chg_q, chg_d, update_q;

  logic [4:0]      off_w;
  logic            ch_hit, ctrl_hit, per_hit, load_hit, stat_hit, err;
  logic            access, wr_en, tick, load_fire;
  logic [DW-1:0]   sel_shadow, ch_wval;
  logic [31:0]     rd_val;
  logic            unused_bits;

  function automatic logic [DW-1:0] merge_dw(input logic [DW-1:0] old_v,
                                             input logic [31:0] wd, input logic [3:0] strb);
    for (int b = 0; b < DW; b++) merge_dw[b] = strb[b/8] ? wd[b] : old_v[b];
  endfunction

  function automatic logic [TW-1:0] merge_tw(input logic [TW-1:0] old_v,
                                             input logic [31:0] wd, input logic [3:0] strb);
    for (int b = 0; b < TW; b++) merge_tw[b] = strb[b/8] ? wd[b] : old_v[b];
  endfunction

  assign unused_bits = ^{PADDR[31:7], PADDR[1:0], PWDATA};

  assign off_w    = PADDR[6:2];
  assign ch_hit   = ({1'b0, off_w} < 6'(NCH));
  assign ctrl_hit = (off_w == 5'd16);
  assign per_hit  = (off_w == 5'd17);
  assign load_hit = (off_w == 5'd18);
  assign stat_hit = (off_w == 5'd19);
  assign err      = !(ch_hit || ctrl_hit || per_hit || load_hit || stat_hit);

  // Each transfer is accepted only from IDLE, giving one wait state and
  // a single-cycle PREADY even when the master holds PSEL/PENABLE high.
  always_comb begin
    state_d = S_IDLE;
    if (state_q == S_IDLE && PSEL && PENABLE) state_d = S_RESP;
  end

  assign access    = (state_q == S_IDLE) && PSEL && PENABLE;
  assign wr_en     = access && PWRITE && !err;
  assign tick      = ten_q && (cnt_q == period_q);
  assign load_fire = tick || (wr_en && load_hit && PWDATA[0] && PSTRB[0]);
  assign ch_wval   = merge_dw(sel_shadow, PWDATA, PSTRB);

  always_comb begin
    sel_shadow = '0;
    for (int n = 0; n < NCH; n++)
      if (off_w == 5'(n)) sel_shadow = shadow_q[n];
  end

  always_comb begin
    rd_val = '0;
    if (ch_hit)        rd_val[DW-1:0] = sel_shadow;
    else if (ctrl_hit) rd_val[1:0]    = {ten_q, mode_q};
    else if (per_hit)  rd_val[TW-1:0] = period_q;
    else if (stat_hit) rd_val[0]      = pend_q;
  end

  always_comb begin
    shadow_d  = shadow_q;
    dout_d    = dout_q;
    mode_d    = mode_q;
    ten_d     = ten_q;
    period_d  = period_q;
    pend_d    = pend_q;
    prdata_d  = (access && !PWRITE && !err) ? rd_val : '0;
    pslverr_d = access && err;
    cnt_d     = (!ten_q || tick) ? '0 : cnt_q + TW'(1);

    // Load first so a coincident shadow write keeps its new value pending.
    if (load_fire) begin
      dout_d = shadow_q;
      pend_d = 1'b0;
    end
    if (wr_en && ch_hit) begin
      for (int n = 0; n < NCH; n++) begin
        if (off_w == 5'(n)) begin
          shadow_d[n] = ch_wval;
          if (!mode_q) dout_d[n] = ch_wval;
        end
      end
      if (mode_q) pend_d = 1'b1;
    end
    if (wr_en && ctrl_hit && PSTRB[0]) begin
      mode_d = PWDATA[0];
      ten_d  = PWDATA[1];
    end
    if (wr_en && per_hit) begin
      period_d = merge_tw(period_q, PWDATA, PSTRB);
      cnt_d    = '0;
    end

    chg_d = 1'b0;
    for (int n = 0; n < NCH; n++)
      if (dout_d[n] != dout_q[n]) chg_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      mode_q    <= 1'b0;
      ten_q     <= 1'b0;
      pend_q    <= 1'b0;
      period_q  <= '0;
      cnt_q     <= '0;
      chg_q     <= 1'b0;
      update_q  <= 1'b0;
      for (int n = 0; n < NCH; n++) begin
        shadow_q[n] <= '0;
        dout_q[n]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      mode_q    <= mode_d;
      ten_q     <= ten_d;
      pend_q    <= pend_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      chg_q     <= chg_d;
      update_q  <= chg_q;
      shadow_q  <= shadow_d;
      dout_q    <= dout_d;
    end
  end

  assign PREADY  = (state_q == S_RESP);
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
  assign UPDATE  = update_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_data
    assign DATA[gi*DW +: DW] = dout_q[gi];
  end

endmodule

// File: tb/tb_dac_apb_multichannel.sv
// Bench for dac_apb_multichannel: directed steps plus randomized APB traffic
// checked against a register-level reference model.
module tb_dac_apb_multichannel;
  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int TW  = 16;
  localparam int CW  = $clog2(NCH);
  localparam logic [31:0] DW_MASK = 32'((64'd1 << DW) - 64'd1);
  localparam logic [31:0] TW_MASK = 32'((64'd1 << TW) - 64'd1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]       paddr = '0, pwdata = '0;
  logic [3:0]        pstrb = '0;
  logic              pready, pslverr, update;
  logic [31:0]       prdata;
  logic [NCH*DW-1:0] data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] m_shadow [NCH];
  logic [31:0] m_out [NCH];
  logic        m_mode, m_ten, m_pend;
  logic [31:0] m_period;

  dac_apb_multichannel #(.NCH(NCH), .DW(DW), .TW(TW)) dut (
    .CLK(clk), .RST(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready),
    .PRDATA(prdata), .PSLVERR(pslverr), .DATA(data), .UPDATE(update)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [NCH*DW-1:0] pack_out();
    logic [NCH*DW-1:0] r;
    for (int n = 0; n < NCH; n++) r[n*DW +: DW] = m_out[n][DW-1:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_shadow[n] = '0;
      m_out[n]    = '0;
    end
    m_mode = 0; m_ten = 0; m_pend = 0; m_period = '0;
  endtask

  // Register-map behaviour, timer assumed disabled
  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] strb, output logic [31:0] exp_rd,
                              output logic exp_err);
    int off;
    logic [CW-1:0] ci;
    logic [31:0] v;
    off = int'(addr[6:2]);
    exp_rd = '0;
    exp_err = 1'b0;
    if (off < 16) begin
      ci = off[CW-1:0];
      if (off >= NCH) exp_err = 1'b1;
      else if (wr) begin
        v = lane_merge(m_shadow[ci], wd, strb) & DW_MASK;
        m_shadow[ci] = v;
        if (!m_mode) m_out[ci] = v;
        else m_pend = 1'b1;
      end else exp_rd = m_shadow[ci];
    end else begin
      case (off)
        16: if (wr) begin
              v = lane_merge({30'b0, m_ten, m_mode}, wd, strb);
              m_mode = v[0];
              m_ten  = v[1];
            end else exp_rd = {30'b0, m_ten, m_mode};
        17: if (wr) m_period = lane_merge(m_period, wd, strb) & TW_MASK;
            else exp_rd = m_period;
        18: if (wr && wd[0] && strb[0]) begin
              for (int n = 0; n < NCH; n++) m_out[n] = m_shadow[n];
              m_pend = 1'b0;
            end
        19: if (!wr) exp_rd = {31'b0, m_pend};
        default: exp_err = 1'b1;
      endcase
    end
  endtask

  // Called just after a clock edge; returns just after the edge following completion.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic slverr, output logic upd,
                          output logic [NCH*DW-1:0] data_c, output int lat,
                          output logic rdy_after);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 8;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (pready) begin
        lat = i;
        break;
      end
    end
    rdata = prdata; slverr = pslverr; data_c = data;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    upd = update; rdy_after = pready;
    $display("txn %s addr=%08h wdata=%08h strb=%h rdata=%08h slverr=%0d",
             wr ? "WR" : "RD", addr, wd, strb, rdata, slverr);
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, output logic [31:0] rd);
    logic [NCH*DW-1:0] prev, exp_data, dc;
    logic [31:0] exp_rd;
    logic exp_err, se, up, ra;
    int lat;
    prev = pack_out();
    model_access(wr, addr, wd, strb, exp_rd, exp_err);
    exp_data = pack_out();
    apb_xfer(wr, addr, wd, strb, rd, se, up, dc, lat, ra);
    chk("latency", 64'(lat), 64'd0);
    chk("pslverr", 64'(se), 64'(exp_err));
    if (!wr) chk("prdata", 64'(rd), 64'(exp_rd));
    chk("data_commit", 64'(dc), 64'(exp_data));
    chk("update", 64'(up), 64'(exp_data != prev));
    chk("pready_drop", 64'(ra), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = '0; pwdata = '1; pstrb = '1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_update", 64'(update), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] rd, addr, wd;
    logic [3:0]  strb;
    logic        wr, se, up, ra;
    logic [NCH*DW-1:0] dc, exp_v;
    int lat, op, off, e_cyc, t_cyc;

    do_reset();
    run_txn(0, 32'h40, '0, 4'h0, rd);
    chk("ctrl_after_reset", 64'(rd), 64'd0);

    // Immediate mode
    run_txn(1, 32'h00, 32'h5555_5555, 4'hF, rd);
    chk("imm_ch0_pins", 64'(data[11:0]), 64'h555);
    run_txn(0, 32'h00, '0, 4'h0, rd);
    chk("imm_ch0_read", 64'(rd), 64'h555);
    run_txn(1, 32'h04, 32'h4444_4444, 4'h1, rd);
    run_txn(0, 32'h04, '0, 4'h0, rd);
    chk("imm_ch1_strb", 64'(rd), 64'h044);

    // Synchronised load
    run_txn(1, 32'h40, 32'h1, 4'hF, rd);
    run_txn(1, 32'h00, 32'h333, 4'hF, rd);
    run_txn(1, 32'h0C, 32'h777, 4'hF, rd);
    run_txn(0, 32'h4C, '0, 4'h0, rd);
    chk("sync_pend_set", 64'(rd), 64'd1);
    run_txn(1, 32'h48, 32'h1, 4'h1, rd);
    chk("sync_ch0", 64'(data[0*DW +: DW]), 64'h333);
    chk("sync_ch3", 64'(data[3*DW +: DW]), 64'h777);
    run_txn(0, 32'h4C, '0, 4'h0, rd);
    chk("sync_pend_clr", 64'(rd), 64'd0);

    // Randomized register traffic with the timer kept disabled
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      wr = 1'b1;
      wd = $urandom();
      strb = 4'($urandom());
      case (op)
        0, 1, 2, 3: off = $urandom_range(0, 7);
        4: begin off = $urandom_range(0, 7); wr = 1'b0; end
        5: begin off = 16; wd = wd & ~32'h2; end
        6: off = 18;
        7: begin off = ($urandom_range(0, 1) != 0) ? 17 : 19; wr = 1'($urandom()); end
        8: begin off = $urandom_range(16, 19); wr = 1'b0; end
        default: begin off = $urandom_range(20, 31); wr = 1'($urandom()); end
      endcase
      addr = ($urandom() & 32'hFFFF_FF83) | (32'(off) << 2);
      run_txn(wr, addr, wd, strb, rd);
    end

    // Timer: MODE=1, PERIOD=9, enable at edge e_cyc, ticks at e_cyc+10k
    do_reset();
    apb_xfer(1, 32'h40, 32'h1, 4'hF, rd, se, up, dc, lat, ra);
    apb_xfer(1, 32'h44, 32'd9, 4'hF, rd, se, up, dc, lat, ra);
    apb_xfer(1, 32'h08, 32'h222, 4'hF, rd, se, up, dc, lat, ra);
    chk("tmr_pending_pins", 64'(dc), 64'd0);
    apb_xfer(1, 32'h40, 32'h3, 4'hF, rd, se, up, dc, lat, ra);
    e_cyc = cyc - 1;
    chk("tmr_enable_update", 64'(up), 64'd0);
    while (cyc < e_cyc + 25) begin
      @(posedge clk); #1;
      exp_v = '0;
      if (cyc >= e_cyc + 10) exp_v[2*DW +: DW] = 12'h222;
      chk("tmr_data", 64'(data), 64'(exp_v));
      chk("tmr_update", 64'(update), 64'(cyc == e_cyc + 11));
    end
    apb_xfer(0, 32'h4C, '0, 4'h0, rd, se, up, dc, lat, ra);
    chk("tmr_pend_clr", 64'(rd), 64'd0);

    // Collision: CH0 write commits on the tick edge t_cyc
    t_cyc = e_cyc + 40;
    while (cyc < t_cyc - 2) begin
      @(posedge clk); #1;
    end
    apb_xfer(1, 32'h00, 32'hABC, 4'hF, rd, se, up, dc, lat, ra);
    exp_v = '0;
    exp_v[2*DW +: DW] = 12'h222;
    chk("coll_old_value", 64'(dc), 64'(exp_v));
    chk("coll_no_update", 64'(up), 64'd0);
    apb_xfer(0, 32'h4C, '0, 4'h0, rd, se, up, dc, lat, ra);
    chk("coll_pend", 64'(rd), 64'd1);
    while (cyc < t_cyc + 9) begin
      @(posedge clk); #1;
    end
    chk("coll_before_tick", 64'(data), 64'(exp_v));
    @(posedge clk); #1;
    exp_v[0 +: DW] = 12'hABC;
    chk("coll_next_tick", 64'(data), 64'(exp_v));
    @(posedge clk); #1;
    chk("coll_update", 64'(update), 64'd1);

    // Back-to-back unmapped writes with PSEL/PENABLE held high
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h5555_5555;
    pwdata = $urandom(); pstrb = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("b2b_pready", 64'(pready), 64'(k % 2));
      chk("b2b_pslverr", 64'(pslverr), 64'(k % 2));
      chk("b2b_prdata", 64'(prdata), 64'd0);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("b2b_data_kept", 64'(data), 64'(exp_v));
    apb_xfer(0, 32'h40, '0, 4'h0, rd, se, up, dc, lat, ra);
    chk("b2b_ctrl_kept", 64'(rd), 64'h3);
    apb_xfer(0, 32'h10, '0, 4'h0, rd, se, up, dc, lat, ra);
    chk("ch4_rd_err", 64'(se), 64'd1);
    chk("ch4_rd_zero", 64'(rd), 64'd0);
    apb_xfer(1, 32'h14, 32'hFFF, 4'hF, rd, se, up, dc, lat, ra);
    chk("ch5_wr_err", 64'(se), 64'd1);
    chk("ch5_wr_nochg", 64'(dc), 64'(exp_v));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
